// File: rtl/phy_stim_gen.sv
// rtl/phy_stim_gen.sv - multi-lane serial COM/LFSR-payload frame stimulus generator
// Optional per-lane output delay lines enabled by PHY_STIM_SKEW_EN.
module phy_stim_gen #(
    parameter int          LANES        = 2,
    parameter int          WIDTH        = 8,
    parameter logic [15:0] COM_SYM      = 16'h00BC,
    parameter int          COM_COUNT    = 4,
    parameter int          PAYLOAD_SYMS = 16,
    parameter int          FRAMES       = 2
) (
    input  logic             clk_8f,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
`ifdef PHY_STIM_SKEW_EN
    input  logic [3*LANES-1:0] lane_skew,
`endif
    output logic [LANES-1:0] data_out,
    output logic             sym_start,
    output logic             is_com,
    output logic             busy,
    output logic             done,
    output logic [15:0]      frame_cnt
);

    localparam int BIT_W = $clog2(WIDTH);
    localparam int SYM_W = 12;
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);
    localparam logic [SYM_W-1:0] COM_LAST = SYM_W'(COM_COUNT - 1);
    localparam logic [SYM_W-1:0] PAY_LAST = SYM_W'(PAYLOAD_SYMS - 1);
    localparam logic [WIDTH-1:0] COM_W    = COM_SYM[WIDTH-1:0];

    typedef enum logic [1:0] {S_IDLE, S_COM, S_DATA, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [SYM_W-1:0]   sym_cnt_q, sym_cnt_d;
    logic [15:0]        frame_cnt_q, frame_cnt_d;
    logic               stop_q, stop_d;
    logic [WIDTH-1:0]   shreg_q [LANES];
    logic [WIDTH-1:0]   shreg_d [LANES];
    logic [15:0]        lfsr_q  [LANES];
    logic [15:0]        lfsr_d  [LANES];
    logic               load_com, load_pay, shift, reseed, frame_more;
    logic [LANES-1:0]   raw_bits;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

    function automatic logic [15:0] lane_seed(input int lane);
        return 16'hACE1 ^ 16'(lane);
    endfunction

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        sym_cnt_d   = sym_cnt_q;
        frame_cnt_d = frame_cnt_q;
        stop_d      = stop_q;
        load_com    = 1'b0;
        load_pay    = 1'b0;
        shift       = 1'b0;
        reseed      = 1'b0;
        // Continuous mode honours a stop raised on the very last bit as well.
        if (FRAMES == 0) frame_more = !(stop_q || stop);
        else             frame_more = ({1'b0, frame_cnt_q} + 17'd1) < 17'(FRAMES);
        case (state_q)
            S_IDLE: begin
                stop_d = 1'b0;
                if (start) begin
                    state_d     = S_COM;
                    bit_cnt_d   = '0;
                    sym_cnt_d   = '0;
                    frame_cnt_d = '0;
                    load_com    = 1'b1;
                    reseed      = 1'b1;
                end
            end
            S_COM, S_DATA: begin
                if (stop) stop_d = 1'b1;
                if (bit_cnt_q != BIT_LAST) begin
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    shift     = 1'b1;
                end else begin
                    bit_cnt_d = '0;
                    if (state_q == S_COM) begin
                        if (sym_cnt_q != COM_LAST) begin
                            sym_cnt_d = sym_cnt_q + SYM_W'(1);
                            load_com  = 1'b1;
                        end else begin
                            state_d   = S_DATA;
                            sym_cnt_d = '0;
                            load_pay  = 1'b1;
                        end
                    end else if (sym_cnt_q != PAY_LAST) begin
                        sym_cnt_d = sym_cnt_q + SYM_W'(1);
                        load_pay  = 1'b1;
                    end else begin
                        sym_cnt_d = '0;
                        if (frame_cnt_q != 16'hFFFF) frame_cnt_d = frame_cnt_q + 16'd1;
                        if (frame_more) begin
                            state_d  = S_COM;
                            load_com = 1'b1;
                        end else begin
                            state_d = S_DONE;
                        end
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            shreg_d[l] = shreg_q[l];
            lfsr_d[l]  = lfsr_q[l];
            if (reseed) lfsr_d[l] = lane_seed(l);
            if (load_com) begin
                shreg_d[l] = COM_W;
            end else if (load_pay) begin
                shreg_d[l] = lfsr_q[l][WIDTH-1:0];
                lfsr_d[l]  = lfsr_next(lfsr_q[l]);
            end else if (shift) begin
                shreg_d[l] = shreg_q[l] << 1;
            end
        end
    end

    always_ff @(posedge clk_8f) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= '0;
            sym_cnt_q   <= '0;
            frame_cnt_q <= '0;
            stop_q      <= 1'b0;
            for (int l = 0; l < LANES; l++) begin
                shreg_q[l] <= '0;
                lfsr_q[l]  <= lane_seed(l);
            end
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            sym_cnt_q   <= sym_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            stop_q      <= stop_d;
            for (int l = 0; l < LANES; l++) begin
                shreg_q[l] <= shreg_d[l];
                lfsr_q[l]  <= lfsr_d[l];
            end
        end
    end

    always_comb begin
        busy      = (state_q == S_COM) || (state_q == S_DATA);
        is_com    = (state_q == S_COM);
        done      = (state_q == S_DONE);
        sym_start = busy && (bit_cnt_q == '0);
        frame_cnt = frame_cnt_q;
        for (int l = 0; l < LANES; l++) raw_bits[l] = busy & shreg_q[l][WIDTH-1];
    end

`ifdef PHY_STIM_SKEW_EN
    logic [2:0] skew_q [LANES];
    logic [2:0] skew_d [LANES];
    logic [6:0] dly_q  [LANES];
    logic [6:0] dly_d  [LANES];

    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            skew_d[l] = (state_q == S_IDLE && start) ? lane_skew[3*l +: 3] : skew_q[l];
            dly_d[l]  = {dly_q[l][5:0], raw_bits[l]};
            data_out[l] = (skew_q[l] == 3'd0) ? raw_bits[l] : dly_q[l][skew_q[l] - 3'd1];
        end
    end

    always_ff @(posedge clk_8f) begin
        for (int l = 0; l < LANES; l++) begin
            if (!reset) begin
                skew_q[l] <= '0;
                dly_q[l]  <= '0;
            end else begin
                skew_q[l] <= skew_d[l];
                dly_q[l]  <= dly_d[l];
            end
        end
    end
`else
    assign data_out = raw_bits;
`endif

endmodule

// File: tb/tb_phy_stim_gen.sv
// tb/tb_phy_stim_gen.sv - scoreboard bench for phy_stim_gen (finite and continuous instances)
module tb_phy_stim_gen;
    localparam int LANES = 2;

    typedef logic [LANES+1:0] ent_t;

    logic clk_8f = 1'b0;
    always #5 clk_8f = ~clk_8f;

    logic             reset, m_start, m_stop, c_start, c_stop, sel, hold_start, cap_en;
    logic [LANES-1:0] m_data, c_data, o_data;
    logic             m_sym, m_com, m_busy, m_done, c_sym, c_com, c_busy, c_done;
    logic             o_sym, o_com, o_busy, o_done;
    logic [15:0]      m_fc, c_fc, o_fc, cap0, cap1;
`ifdef PHY_STIM_SKEW_EN
    logic [3*LANES-1:0] lane_skew;
`endif

    ent_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    phy_stim_gen dut (
        .clk_8f(clk_8f), .reset(reset), .start(m_start), .stop(m_stop),
`ifdef PHY_STIM_SKEW_EN
        .lane_skew(lane_skew),
`endif
        .data_out(m_data), .sym_start(m_sym), .is_com(m_com), .busy(m_busy),
        .done(m_done), .frame_cnt(m_fc)
    );

    phy_stim_gen #(.FRAMES(0)) dut_c (
        .clk_8f(clk_8f), .reset(reset), .start(c_start), .stop(c_stop),
`ifdef PHY_STIM_SKEW_EN
        .lane_skew('0),
`endif
        .data_out(c_data), .sym_start(c_sym), .is_com(c_com), .busy(c_busy),
        .done(c_done), .frame_cnt(c_fc)
    );

    always_comb begin
        o_data = sel ? c_data : m_data;
        o_sym  = sel ? c_sym  : m_sym;
        o_com  = sel ? c_com  : m_com;
        o_busy = sel ? c_busy : m_busy;
        o_done = sel ? c_done : m_done;
        o_fc   = sel ? c_fc   : m_fc;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

    // Reference stream: 4 COM symbols then 16 payload symbols per frame, MSB first.
    task automatic push_run(input int nframes);
        logic [15:0] s [LANES];
        logic [7:0]  sym [LANES];
        logic [7:0]  com_v;
        ent_t        e;
        com_v = 8'hBC;
        for (int l = 0; l < LANES; l++) s[l] = 16'hACE1 ^ 16'(l);
        for (int f = 0; f < nframes; f++) begin
            for (int c = 0; c < 4; c++)
                for (int b = 0; b < 8; b++) begin
                    for (int l = 0; l < LANES; l++) e[l+2] = com_v[7-b];
                    e[1] = (b == 0);
                    e[0] = 1'b1;
                    exp_q.push_back(e);
                end
            for (int p = 0; p < 16; p++) begin
                for (int l = 0; l < LANES; l++) begin
                    sym[l] = s[l][7:0];
                    s[l]   = lfsr_step(s[l]);
                end
                for (int b = 0; b < 8; b++) begin
                    for (int l = 0; l < LANES; l++) e[l+2] = sym[l][7-b];
                    e[1] = (b == 0);
                    e[0] = 1'b0;
                    exp_q.push_back(e);
                end
            end
        end
    endtask

    task automatic run_watch(input string tag, input int abort_at, output int busy_cnt,
                             output bit saw_done, output bit first_busy);
        ent_t e;
        busy_cnt = 0; saw_done = 0; first_busy = 0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(posedge clk_8f); #1;
            if (cyc == 0) first_busy = o_busy;
            if (!hold_start) begin m_start = 1'b0; c_start = 1'b0; end
            if (o_done) begin saw_done = 1; break; end
            if (o_busy) begin
                if (cap_en && busy_cnt >= 32 && busy_cnt < 48) begin
                    cap0 = {cap0[14:0], o_data[0]};
                    cap1 = {cap1[14:0], o_data[1]};
                end
                if (exp_q.size() == 0) check({tag, "_extra"}, 32'd1, 32'd0);
                else begin
                    e = exp_q.pop_front();
                    check(tag, 32'({o_data, o_sym, o_com}), 32'(e));
                end
                busy_cnt++;
                c_stop = sel && (o_fc == 16'd2) && !o_com;
                if (busy_cnt == abort_at) break;
            end
        end
        if (!saw_done && busy_cnt != abort_at) check({tag, "_timeout"}, 32'd0, 32'd1);
        c_stop = 1'b0;
    endtask

    initial begin
        int   bc, gap;
        bit   sd, fb, got;
        ent_t e;
        reset = 0; m_start = 0; m_stop = 0; c_start = 0; c_stop = 0;
        sel = 0; hold_start = 0; cap_en = 0; cap0 = '0; cap1 = '0;
`ifdef PHY_STIM_SKEW_EN
        lane_skew = '0;
`endif
        repeat (8) @(posedge clk_8f);
        @(negedge clk_8f);
        check("rst_outs", 32'({m_data, m_sym, m_com, m_busy, m_done}), 32'd0);
        check("rst_frame", 32'(m_fc), 32'd0);
        check("rst_outs_c", 32'({c_data, c_busy, c_done, c_fc}), 32'd0);
        reset = 1;

        // Full default run
        @(negedge clk_8f);
        push_run(2); cap_en = 1; m_start = 1;
        run_watch("run1", 0, bc, sd, fb);
        cap_en = 0;
        check("run1_latency_busy", 32'(fb), 32'd1);
        check("run1_busy_cycles", bc, 320);
        check("run1_done", 32'(sd), 32'd1);
        check("run1_queue_left", exp_q.size(), 0);
        check("lane0_payload", 32'(cap0), 32'hE170);
        check("lane1_payload", 32'(cap1), 32'hE070);
        @(posedge clk_8f); #1;
        check("run1_done_once", 32'({m_done, m_busy}), 32'd0);
        check("run1_frame_cnt", 32'(m_fc), 32'd2);

        // Reset mid-frame, then restart must replay the same stream
        @(negedge clk_8f);
        push_run(2); m_start = 1;
        run_watch("run2a", 50, bc, sd, fb);
        check("run2a_cycles", bc, 50);
        @(negedge clk_8f); reset = 0;
        @(posedge clk_8f); #1;
        check("midrst_outs", 32'({m_data, m_busy, m_sym, m_com}), 32'd0);
        exp_q.delete();
        @(negedge clk_8f); reset = 1;
        @(negedge clk_8f);
        push_run(2); m_start = 1;
        run_watch("run2b", 0, bc, sd, fb);
        check("run2b_busy_cycles", bc, 320);
        check("run2b_done", 32'(sd), 32'd1);

        // start held high: back-to-back runs with one IDLE cycle between
        @(negedge clk_8f);
        push_run(2); push_run(2); hold_start = 1; m_start = 1;
        run_watch("b2b1", 0, bc, sd, fb);
        check("b2b1_busy_cycles", bc, 320);
        gap = 0; got = 0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk_8f); #1;
            if (m_busy) begin got = 1; break; end
            gap++;
        end
        check("b2b_gap", gap, 1);
        check("b2b_restart", 32'(got), 32'd1);
        if (got) begin
            e = exp_q.pop_front();
            check("b2b2_first", 32'({m_data, m_sym, m_com}), 32'(e));
        end
        hold_start = 0; m_start = 0;
        run_watch("b2b2", 0, bc, sd, fb);
        check("b2b2_busy_cycles", bc, 319);
        check("b2b2_frame_cnt", 32'(m_fc), 32'd2);

        // Continuous mode stopped during frame 3 payload
        @(negedge clk_8f);
        exp_q.delete();
        sel = 1;
        push_run(3); c_start = 1;
        run_watch("cont", 0, bc, sd, fb);
        check("cont_busy_cycles", bc, 480);
        check("cont_done", 32'(sd), 32'd1);
        @(posedge clk_8f); #1;
        check("cont_done_once", 32'({c_done, c_busy}), 32'd0);
        check("cont_frame_cnt", 32'(c_fc), 32'd3);
        repeat (20) @(posedge clk_8f); #1;
        check("cont_stays_idle", 32'({c_done, c_busy}), 32'd0);
        sel = 0;

`ifdef PHY_STIM_SKEW_EN
        begin
            logic [39:0] l0, l1;
            @(negedge clk_8f);
            lane_skew = {3'd3, 3'd0}; m_start = 1;
            for (int t = 0; t < 40; t++) begin
                @(posedge clk_8f); #1;
                m_start = 0;
                l0[t] = m_data[0];
                l1[t] = m_data[1];
            end
            for (int t = 0; t < 35; t++)
                check("skew_lane1", 32'(l1[t]), (t < 3) ? 32'd0 : 32'(l0[t-3]));
            for (int k = 0; k < 400 && !m_done; k++) begin
                @(posedge clk_8f); #1;
            end
            check("skew_done", 32'(m_done), 32'd1);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/phy_stim_gen.md
Name: phy_stim_gen

Overview:
- Synthesizable, parametrised serial lane stimulus generator for PHY receive-path bring-up and on-chip self-test; it supersedes hand-written bit-by-bit stimulus.
- Per lane, per frame: COM_COUNT alignment symbols (COM_SYM), then PAYLOAD_SYMS pseudo-random symbols, sent serially MSB-first, one bit per clk_8f.
- All lanes share one sequencer; each lane has its own LFSR.
- Output drives the data_in lanes of phy_rx directly.

Parameters:
- LANES, 2, number of serial output lanes (1..8).
- WIDTH, 8, symbol width in bits (4..16).
- COM_SYM, 8'hBC, alignment symbol; low WIDTH bits are used.
- COM_COUNT, 4, COM symbols per frame (1..255).
- PAYLOAD_SYMS, 16, payload symbols per frame (1..4095).
- FRAMES, 2, frames per start; 0 = continuous until stop.

Ports:
- clk_8f  in  1  bit clock.
- reset  in  1  synchronous, active-low reset.
- start  in  1  begin a run; sampled only in IDLE.
- stop  in  1  continuous mode only: finish the current frame, then end.
- data_out  out  LANES  serial bit per lane.
- sym_start  out  1  high on the first bit of every symbol.
- is_com  out  1  high for every bit of a COM symbol.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse after the last bit of the run.
- frame_cnt  out  16  frames completed in the current run.

Behaviour:
- Clocking and reset: one clock, clk_8f. reset is synchronous and active-low.
- With reset low at a clk_8f edge:
  - all outputs go to 0;
  - state goes to IDLE;
  - bit, symbol and frame counters clear;
  - lane i LFSR reloads seed 16'hACE1 ^ i.
- States:
  - IDLE: data_out=0, busy=0. start=1 goes to COM. start is a level, not an edge.
  - COM: shift COM_SYM MSB-first on every lane. After COM_COUNT symbols go to DATA.
  - DATA: per symbol, load lane LFSR[WIDTH-1:0] into the lane shifter and advance the LFSR once. Shift MSB-first.
  - End of a frame's last payload symbol: frame_cnt increments.
    - Go to COM if (FRAMES==0 and stop not latched) or frame_cnt+1 < FRAMES.
    - Otherwise go to DONE.
  - DONE: lasts one cycle; done=1, busy=0, data_out=0. Then IDLE.
- Latency: start sampled high in IDLE gives data_out = COM_SYM MSB on the next cycle, with busy=1 and sym_start=1 in that same cycle.
- No gap bits: consecutive symbols and frames are contiguous. sym_start is high every WIDTH cycles while busy.
- LFSR per lane, 16-bit Fibonacci: fb = s[0]^s[2]^s[3]^s[5]; next = {fb, s[15:1]}.
  - The LFSR is not reseeded between frames, only at reset or on the IDLE to COM transition.
  - Payload is therefore reproducible per run.
- stop: any cycle it is high while busy, it latches. The latch clears in IDLE. It is ignored when FRAMES!=0.
- start while busy or in DONE: ignored.
- frame_cnt: holds its final value in IDLE and clears on the next start. At 16-bit max it saturates.
- Reset mid-frame: outputs go to 0 the following cycle. A subsequent start reproduces a bit-identical run.
- Total run length, FRAMES=F>0: F*(COM_COUNT+PAYLOAD_SYMS)*WIDTH busy cycles, then one DONE cycle.

Optional Feature:
- Macro: PHY_STIM_SKEW_EN.
- Defined:
  - Adds input lane_skew [3*LANES-1:0].
  - Lane i output passes through a 0..7-stage delay line set by lane_skew[3i+2:3i]. Stages fill with 0 on reset.
  - lane_skew is sampled on the IDLE to COM transition and held for the run.
  - Skewed lanes emit their last bits up to 7 cycles after done. busy, done, sym_start and is_com refer to the undelayed stream.
- Undefined: no lane_skew port; all lanes are bit-aligned with zero added delay.

Test Plan:
- Defaults, reset low 8 cycles, then start pulse:
  - data_out[0] first 32 bits = 10111100 repeated 4 times; is_com=1 for exactly those 32 cycles;
  - sym_start at cycle offsets 0, 8, 16, ...
- First payload symbols:
  - lane0 = 0xE1 then 0x70;
  - lane1 = 0xE0 then 0x70 (0x70 from next state 0xD670).
- Defaults full run:
  - busy high exactly 320 cycles, then done one cycle;
  - frame_cnt=2 after done;
  - second frame starts with 4 COM symbols, not new payload, and payload continues the LFSR sequence.
- FRAMES=0: assert stop during frame 3 payload -> run ends after frame 3 last bit, frame_cnt=3, done pulses once.
- Reset mid-frame and restart:
  - reset low at cycle 50 of the run -> data_out=0, busy=0 next cycle;
  - new start -> bit stream identical to the first run from bit 0.
- start held high continuously -> back-to-back runs, with exactly one IDLE cycle between DONE and the next COM.
- PHY_STIM_SKEW_EN with lane_skew={3'd3,3'd0} -> lane1 equals lane0 delayed 3 cycles, with leading zeros.
